// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, whole-matrix debounce, key code + status read by the CPU.
// Press-to-ready is DEBOUNCE_SCANS to DEBOUNCE_SCANS+1 scans plus sync delay; dataOut trails n_rd by 3 clk.
// No backpressure: an unread code is replaced by a new press and flagged as overrun.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       n_rd,
    input  logic       addr,
    output logic [7:0] dataOut,
    output logic [3:0] col_out,
    input  logic [3:0] row_in,
    output logic       n_int
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

    logic [3:0]    row_meta_q, row_sync_q;
    logic          rd_meta_q, rd_sync_q, rd_prev_q;
    logic          addr_q, addr_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    col_q, col_d;
    logic [15:0]   raw_q, raw_d, cand_q, cand_d, deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d, key_idx;
    logic          ready_q, ready_d, ovr_q, ovr_d;
    logic [7:0]    dout_q, dout_d;
    logic          tc, scan_end, one_hot, key_evt, rd_fall, rd_rise, ack;

    always_comb begin
        tc       = (div_q == DIV_LAST);
        scan_end = tc && (col_q == 2'd3);
        div_d    = tc ? '0 : div_q + 1'b1;
        col_d    = tc ? col_q + 2'd1 : col_q;
        raw_d    = raw_q;
        if (tc) begin
            raw_d[{col_q, 2'b00} +: 4] = ~row_sync_q;
        end

        // Debounce compares whole snapshots, so only the complete raw (incl. column 3) is used.
        cand_d = cand_q;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (scan_end) begin
            if (raw_d != cand_q) begin
                cand_d = raw_d;
                cnt_d  = '0;
            end else begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cnt_d == CNT_LAST) begin
                    deb_d = cand_q;
                end
            end
        end

        one_hot = (deb_d != 16'h0000) && ((deb_d & (deb_d - 16'd1)) == 16'h0000);
        key_evt = (deb_q == 16'h0000) && one_hot;
        key_idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (deb_d[i]) begin
                key_idx = 4'(i);
            end
        end

        rd_fall = !rd_sync_q && rd_prev_q;
        rd_rise = rd_sync_q && !rd_prev_q;
        ack     = rd_rise && !addr_q;
        addr_d  = rd_fall ? addr : addr_q;

        // A key event in the same cycle as a code-read acknowledge wins; the old code counts as consumed.
        code_d  = code_q;
        ready_d = ready_q;
        ovr_d   = ovr_q;
        if (ack) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (key_evt) begin
            code_d  = key_idx;
            ready_d = 1'b1;
            ovr_d   = ack ? 1'b0 : ready_q;
        end

        if (rd_sync_q) begin
            dout_d = 8'h00;
        end else if (addr_d) begin
            dout_d = {6'h00, ovr_q, ready_q};
        end else begin
            dout_d = {4'h0, code_q};
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            rd_meta_q  <= 1'b1;
            rd_sync_q  <= 1'b1;
            rd_prev_q  <= 1'b1;
            addr_q     <= 1'b0;
            div_q      <= '0;
            col_q      <= 2'd0;
            raw_q      <= 16'h0000;
            cand_q     <= 16'h0000;
            deb_q      <= 16'h0000;
            cnt_q      <= '0;
            code_q     <= 4'h0;
            ready_q    <= 1'b0;
            ovr_q      <= 1'b0;
            dout_q     <= 8'h00;
        end else begin
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
            rd_meta_q  <= n_rd;
            rd_sync_q  <= rd_meta_q;
            rd_prev_q  <= rd_sync_q;
            addr_q     <= addr_d;
            div_q      <= div_d;
            col_q      <= col_d;
            raw_q      <= raw_d;
            cand_q     <= cand_d;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            ready_q    <= ready_d;
            ovr_q      <= ovr_d;
            dout_q     <= dout_d;
        end
    end

    assign col_out = ~(4'b0001 << col_q);
    assign n_int   = ~ready_q;
    assign dataOut = dout_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a keypad matrix model; read data is checked against a queue of expected values.
module tb_keypad_scanner;
    localparam int SD   = 4;
    localparam int DS   = 2;
    localparam int SCAN = 4 * SD;

    logic       clk = 1'b0;
    logic       n_reset, n_rd, addr, n_int;
    logic [7:0] dataOut;
    logic [3:0] col_out, row_in;
    logic [15:0] keys;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .n_reset(n_reset), .n_rd(n_rd), .addr(addr),
        .dataOut(dataOut), .col_out(col_out), .row_in(row_in), .n_int(n_int)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col_out[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[c*4+r]) row_in[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, {8'h00, dataOut}, 16'hFFFF);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {8'h00, dataOut}, {8'h00, exp});
        end
    endtask

    task automatic cpu_read(input logic a, input string tag);
        addr = a;
        n_rd = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        pop_check(tag);
        n_rd = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic wait_scans(input int n);
        repeat (n * SCAN) @(posedge clk);
        #1;
    endtask

    task automatic wait_int(input int budget, input string tag);
        int n = 0;
        while (n_int !== 1'b0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, {15'h0, n_int}, 16'h0000);
    endtask

    task automatic sync_col(input logic [3:0] target);
        logic [3:0] prev;
        logic       found;
        int         n;
        prev  = col_out;
        found = 1'b0;
        n     = 0;
        while (!found && n < 2 * SCAN) begin
            @(posedge clk);
            #1;
            n++;
            if (col_out == target && prev != target) found = 1'b1;
            prev = col_out;
        end
        check("sync_col", {15'h0, found}, 16'h0001);
    endtask

    initial begin
        int lows;
        keys = 16'h0000; n_rd = 1'b1; addr = 1'b0; n_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", {12'h0, col_out}, 16'h000E);
        check("rst_int", {15'h0, n_int}, 16'h0001);
        check("rst_dout", {8'h0, dataOut}, 16'h0000);
        n_reset = 1'b1;
        repeat (7) @(posedge clk);
        #3 n_reset = 1'b0;
        #1;
        check("rst_mid_col", {12'h0, col_out}, 16'h000E);
        check("rst_mid_int", {15'h0, n_int}, 16'h0001);
        #4 n_reset = 1'b1;
        exp_q.push_back(8'h00); cpu_read(1'b1, "rst_status");

        // Single press col 2 row 1
        keys[9] = 1'b1;
        wait_int(3 * SCAN + 4, "single_int");
        exp_q.push_back(8'h01); cpu_read(1'b1, "single_status");
        exp_q.push_back(8'h09); cpu_read(1'b0, "single_code");
        check("single_ack_int", {15'h0, n_int}, 16'h0001);
        check("idle_dout", {8'h0, dataOut}, 16'h0000);
        exp_q.push_back(8'h00); cpu_read(1'b1, "single_status_clr");
        keys = 16'h0000;
        wait_scans(4);

        // Bounce col 0 row 0, phased so no two consecutive column-0 samples agree
        sync_col(4'b1110);
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            keys[0] = (i % 2 == 0);
            repeat (5) begin
                @(posedge clk);
                #1;
                if (!n_int) lows++;
            end
        end
        check("bounce_quiet", 16'(lows), 16'h0000);
        keys[0] = 1'b1;
        wait_int(3 * SCAN + 4, "bounce_int");
        exp_q.push_back(8'h00); cpu_read(1'b0, "bounce_code");
        wait_scans(3);
        check("bounce_single", {15'h0, n_int}, 16'h0001);
        keys = 16'h0000;
        wait_scans(4);

        // Overrun: two presses without reading
        keys[7] = 1'b1;
        wait_int(3 * SCAN + 4, "ovr_int1");
        keys = 16'h0000;
        wait_scans(4);
        keys[15] = 1'b1;
        wait_scans(4);
        keys = 16'h0000;
        exp_q.push_back(8'h03); cpu_read(1'b1, "ovr_status");
        exp_q.push_back(8'h0F); cpu_read(1'b0, "ovr_code");
        exp_q.push_back(8'h00); cpu_read(1'b1, "ovr_status_clr");
        check("ovr_ack_int", {15'h0, n_int}, 16'h0001);
        wait_scans(4);

        // Multi-key press gives no event
        sync_col(4'b1110);
        keys[1] = 1'b1;
        keys[6] = 1'b1;
        wait_scans(4);
        check("multi_no_evt", {15'h0, n_int}, 16'h0001);
        exp_q.push_back(8'h00); cpu_read(1'b1, "multi_status");
        keys = 16'h0000;
        wait_scans(4);
        keys[12] = 1'b1;
        wait_int(3 * SCAN + 4, "multi_next_int");
        exp_q.push_back(8'h0C); cpu_read(1'b0, "multi_next_code");
        keys = 16'h0000;
        wait_scans(4);

        // Collision: code-read acknowledge lands on the clk of a new key latch
        keys[2] = 1'b1;
        wait_int(3 * SCAN + 4, "coll_int1");
        keys = 16'h0000;
        wait_scans(4);
        addr = 1'b0;
        n_rd = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        exp_q.push_back(8'h02); pop_check("coll_old_code");
        sync_col(4'b1110);
        keys[5] = 1'b1;
        sync_col(4'b0111);
        sync_col(4'b0111);
        @(posedge clk);
        #1 n_rd = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("coll_ready", {15'h0, n_int}, 16'h0000);
        exp_q.push_back(8'h01); cpu_read(1'b1, "coll_status");
        exp_q.push_back(8'h05); cpu_read(1'b0, "coll_code");
        check("coll_ack_int", {15'h0, n_int}, 16'h0001);
        keys = 16'h0000;
        wait_scans(4);

        // Reset mid-debounce with key held through it
        keys[9] = 1'b1;
        repeat (SCAN + 3) @(posedge clk);
        #2 n_reset = 1'b0;
        #1;
        check("rst_deb_col", {12'h0, col_out}, 16'h000E);
        check("rst_deb_int", {15'h0, n_int}, 16'h0001);
        #4 n_reset = 1'b1;
        wait_int((DS + 1) * SCAN + 4, "rst_deb_evt");
        exp_q.push_back(8'h09); cpu_read(1'b0, "rst_deb_code");
        keys = 16'h0000;

        check("queue_empty", 16'(exp_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
